// File: rtl/operand_loader.sv
// Packs a serial valid/ready stream of signed samples into (a, b, c) triples and
// presents each completed triple for HOLD cycles to the downstream max stage.
//
// state  | meaning
// S_A    | waiting for operand a
// S_B    | waiting for operand b
// S_C    | waiting for operand c
// S_HOLD | triple presented, input stalled until hold counter expires
module operand_loader #(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic        [N-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic signed [N-1:0] a,
    output logic signed [N-1:0] b,
    output logic signed [N-1:0] c,
    output logic                triple_valid,
    output logic        [7:0]   triple_count
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_C    = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] c_q, c_d;
    logic         triple_valid_q, triple_valid_d;
    logic [7:0]   triple_count_q, triple_count_d;
    logic [7:0]   hold_cnt_q, hold_cnt_d;
    logic         xfer;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_A;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            triple_valid_q <= 1'b0;
            triple_count_q <= 8'd0;
            hold_cnt_q     <= 8'd0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            c_q            <= c_d;
            triple_valid_q <= triple_valid_d;
            triple_count_q <= triple_count_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        c_d            = c_q;
        triple_valid_d = triple_valid_q;
        triple_count_d = triple_count_q;
        hold_cnt_d     = hold_cnt_q;
        in_ready       = (state_q != S_HOLD) && !flush;
        xfer           = in_valid && in_ready;

        // flush outranks everything; in_ready is already low so no sample lands
        if (flush) begin
            state_d        = S_A;
            triple_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_A: begin
                    if (xfer) begin
                        a_d     = in_data;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (xfer) begin
                        b_d     = in_data;
                        state_d = S_C;
                    end
                end
                S_C: begin
                    if (xfer) begin
                        c_d            = in_data;
                        state_d        = S_HOLD;
                        hold_cnt_d     = HOLD_LOAD;
                        triple_valid_d = 1'b1;
                        triple_count_d = triple_count_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q != 8'd0) begin
                        hold_cnt_d = hold_cnt_q - 8'd1;
                    end else begin
                        state_d        = S_A;
                        triple_valid_d = 1'b0;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    assign a            = a_q;
    assign b            = b_q;
    assign c            = c_q;
    assign triple_valid = triple_valid_q;
    assign triple_count = triple_count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: HOLD=2 vector table, HOLD=1 wrap run,
// and asynchronous reset during the hold phase.
module tb_operand_loader;

    logic       clock;
    logic       reset_n;
    logic [3:0] in_data, in_data1;
    logic       in_valid, in_valid1;
    logic       flush, flush1;
    logic       in_ready, in_ready1;
    logic [3:0] a, b, c, a1, b1, c1;
    logic       triple_valid, triple_valid1;
    logic [7:0] triple_count, triple_count1;

    int n_checks = 0;
    int n_pass   = 0;

    operand_loader #(.N(4), .HOLD(2)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .a(a), .b(b), .c(c),
        .triple_valid(triple_valid), .triple_count(triple_count)
    );

    operand_loader #(.N(4), .HOLD(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .flush(flush1), .a(a1), .b(b1), .c(c1),
        .triple_valid(triple_valid1), .triple_count(triple_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       f;
        logic       r;
        logic       tv;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] ec;
        logic [7:0] n;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] d, input logic f, input logic r,
                       input logic tv, input logic [3:0] ea, input logic [3:0] eb,
                       input logic [3:0] ec, input logic [7:0] n);
        vec_t e;
        e.v = v; e.d = d; e.f = f; e.r = r; e.tv = tv;
        e.ea = ea; e.eb = eb; e.ec = ec; e.n = n;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        int pat_err;
        int data_err;
        logic [3:0] t4;

        // inputs applied before the edge; expectations are the outputs seen before that edge
        //  v  d      f  rdy tv a      b      c      cnt
        add(1, 4'h3, 0, 1, 0, 4'h0, 4'h0, 4'h0, 8'd0);
        add(1, 4'hE, 0, 1, 0, 4'h3, 4'h0, 4'h0, 8'd0);
        add(1, 4'h7, 0, 1, 0, 4'h3, 4'hE, 4'h0, 8'd0);
        add(1, 4'h5, 0, 0, 1, 4'h3, 4'hE, 4'h7, 8'd1);
        add(1, 4'h5, 0, 0, 1, 4'h3, 4'hE, 4'h7, 8'd1);
        add(0, 4'h0, 0, 1, 0, 4'h3, 4'hE, 4'h7, 8'd1);
        add(1, 4'h1, 0, 1, 0, 4'h3, 4'hE, 4'h7, 8'd1);
        add(0, 4'h9, 0, 1, 0, 4'h1, 4'hE, 4'h7, 8'd1);
        add(0, 4'h9, 0, 1, 0, 4'h1, 4'hE, 4'h7, 8'd1);
        add(0, 4'h9, 0, 1, 0, 4'h1, 4'hE, 4'h7, 8'd1);
        add(1, 4'h2, 0, 1, 0, 4'h1, 4'hE, 4'h7, 8'd1);
        add(0, 4'h9, 0, 1, 0, 4'h1, 4'h2, 4'h7, 8'd1);
        add(1, 4'h8, 0, 1, 0, 4'h1, 4'h2, 4'h7, 8'd1);
        add(0, 4'h0, 0, 0, 1, 4'h1, 4'h2, 4'h8, 8'd2);
        add(0, 4'h0, 0, 0, 1, 4'h1, 4'h2, 4'h8, 8'd2);
        add(0, 4'h0, 0, 1, 0, 4'h1, 4'h2, 4'h8, 8'd2);
        add(1, 4'h5, 0, 1, 0, 4'h1, 4'h2, 4'h8, 8'd2);
        add(1, 4'h6, 0, 1, 0, 4'h5, 4'h2, 4'h8, 8'd2);
        add(0, 4'h0, 1, 0, 0, 4'h5, 4'h6, 4'h8, 8'd2);
        add(1, 4'h0, 0, 1, 0, 4'h5, 4'h6, 4'h8, 8'd2);
        add(1, 4'h1, 0, 1, 0, 4'h0, 4'h6, 4'h8, 8'd2);
        add(1, 4'h2, 0, 1, 0, 4'h0, 4'h1, 4'h8, 8'd2);
        add(0, 4'h0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'd3);
        add(0, 4'h0, 0, 0, 1, 4'h0, 4'h1, 4'h2, 8'd3);
        add(0, 4'h0, 0, 1, 0, 4'h0, 4'h1, 4'h2, 8'd3);
        add(1, 4'h3, 0, 1, 0, 4'h0, 4'h1, 4'h2, 8'd3);
        add(1, 4'h4, 1, 0, 0, 4'h3, 4'h1, 4'h2, 8'd3);
        add(1, 4'h6, 0, 1, 0, 4'h3, 4'h1, 4'h2, 8'd3);
        add(1, 4'h7, 0, 1, 0, 4'h6, 4'h1, 4'h2, 8'd3);
        add(1, 4'hF, 0, 1, 0, 4'h6, 4'h7, 4'h2, 8'd3);
        add(0, 4'h0, 1, 0, 1, 4'h6, 4'h7, 4'hF, 8'd4);
        add(0, 4'h0, 0, 1, 0, 4'h6, 4'h7, 4'hF, 8'd4);

        reset_n = 1'b0;
        in_data = '0; in_valid = 1'b0; flush = 1'b0;
        in_data1 = '0; in_valid1 = 1'b0; flush1 = 1'b0;
        #12;
        chk("rst_ready", in_ready, 1);
        chk("rst_tv", triple_valid, 0);
        chk("rst_abc", {a, b, c}, 12'h000);
        chk("rst_count", triple_count, 0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            flush    = vecs[i].f;
            #1;
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].r);
            chk($sformatf("v%0d_tv", i), triple_valid, vecs[i].tv);
            chk($sformatf("v%0d_abc", i), {a, b, c}, {vecs[i].ea, vecs[i].eb, vecs[i].ec});
            chk($sformatf("v%0d_count", i), triple_count, vecs[i].n);
        end
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;

        // HOLD=1: 256 back-to-back triples, one every 4 cycles
        pat_err = 0;
        data_err = 0;
        for (int t = 0; t < 256; t++) begin
            t4 = 4'(t);
            for (int p = 0; p < 4; p++) begin
                @(negedge clock);
                in_valid1 = 1'b1;
                in_data1  = (p == 0) ? t4 : (p == 1) ? ~t4 : (t4 ^ 4'h5);
                #1;
                if (in_ready1 !== (p != 3) || triple_valid1 !== (p == 3)) pat_err++;
                if (p == 3) begin
                    if ({a1, b1, c1} !== {t4, ~t4, t4 ^ 4'h5}) data_err++;
                    if (triple_count1 !== 8'(t + 1)) data_err++;
                    if (t == 254) chk("h1_count_255", triple_count1, 255);
                    if (t == 255) chk("h1_count_wrap", triple_count1, 0);
                end
            end
        end
        chk("h1_pattern_errors", pat_err, 0);
        chk("h1_data_errors", data_err, 0);
        @(negedge clock);
        in_valid1 = 1'b0;

        // reset asserted mid-hold with no clock edge in between
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = 4'(i + 9);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        chk("pre_rst_tv", triple_valid, 1);
        chk("pre_rst_ready", in_ready, 0);
        chk("pre_rst_abc", {a, b, c}, 12'h9AB);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_abc", {a, b, c}, 12'h000);
        chk("async_rst_tv", triple_valid, 0);
        chk("async_rst_count", triple_count, 0);
        chk("async_rst_ready", in_ready, 1);
        chk("async_rst_count1", triple_count1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
